// File: rtl/sprite_line_fetcher_if.sv
// sprite_line_fetcher_if
//   Bundles the request, storage-read and line-buffer-write signals of the
//   sprite line fetcher.
//   slave  : fetcher view (takes requests and r_data, drives everything else)
//   master : environment view (scheduler, storage and line buffer side)
//   Signals:
//     start/sprite_id/sprite_x/sprite_row : request from the scheduler
//     busy/done                           : request status
//     sprite_select/r_en/r_addr/r_data    : storage read port (1-cycle latency)
//     lb_w_en/lb_w_addr/lb_w_data         : line buffer write port
//     dbg_state                           : fetcher FSM state, for observation
interface sprite_line_fetcher_if #(
   parameter int SPRITE_NUM = 16,
   parameter int SPRITE_W   = 32,
   parameter int SPRITE_H   = 32,
   parameter int LINE_W     = 640
);
   localparam int ID_W   = $clog2(SPRITE_NUM);
   localparam int ROW_W  = $clog2(SPRITE_H) + 1;
   localparam int ADDR_W = $clog2(SPRITE_W * SPRITE_H);
   localparam int LB_W   = $clog2(LINE_W);

   logic                start;
   logic [ID_W-1:0]     sprite_id;
   logic signed [10:0]  sprite_x;
   logic [ROW_W-1:0]    sprite_row;
   logic                busy;
   logic                done;
   logic [ID_W-1:0]     sprite_select;
   logic                r_en;
   logic [ADDR_W-1:0]   r_addr;
   logic [3:0]          r_data;
   logic                lb_w_en;
   logic [LB_W-1:0]     lb_w_addr;
   logic [3:0]          lb_w_data;
   logic [1:0]          dbg_state;

   modport slave (
      input  start, sprite_id, sprite_x, sprite_row, r_data,
      output busy, done, sprite_select, r_en, r_addr,
             lb_w_en, lb_w_addr, lb_w_data, dbg_state
   );

   modport master (
      output start, sprite_id, sprite_x, sprite_row, r_data,
      input  busy, done, sprite_select, r_en, r_addr,
             lb_w_en, lb_w_addr, lb_w_data, dbg_state
   );
endinterface

// File: rtl/sprite_line_fetcher.sv
// sprite_line_fetcher
//   Fetches one row of one sprite from sprite storage, one 4-bit pixel per
//   cycle, and writes the opaque, on-screen pixels into the scanline buffer
//   at horizontal offset sprite_x.
//   Ports:
//     clk   : system clock, rising edge
//     reset : synchronous, active-high
//     bus   : sprite_line_fetcher_if.slave (request, storage read, line
//             buffer write, FSM state for observation)
//
//   Request handshake: start is looked at only while idle; a start seen in
//   IDLE is accepted on that edge and its sprite_id/sprite_x/sprite_row are
//   latched. busy is high while the row is being read and written, done
//   pulses for exactly one cycle when the request ends. A start presented
//   while not idle (including the done cycle) is dropped, never queued.
module sprite_line_fetcher #(
   parameter int SPRITE_NUM = 16,
   parameter int SPRITE_W   = 32,
   parameter int SPRITE_H   = 32,
   parameter int LINE_W     = 640
) (
   input  logic                   clk,
   input  logic                   reset,
   sprite_line_fetcher_if.slave   bus
);
   localparam int ID_W   = $clog2(SPRITE_NUM);
   localparam int ROW_W  = $clog2(SPRITE_H) + 1;
   localparam int COL_W  = $clog2(SPRITE_W);
   localparam int ADDR_W = $clog2(SPRITE_W * SPRITE_H);
   localparam int LB_W   = $clog2(LINE_W);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic signed [10:0] x_q, x_d;
   logic [COL_W-1:0]   col_q, col_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   // Read-pipeline stage aligned with r_data: valid bit and the 12-bit
   // signed screen x of the pixel arriving from storage.
   logic               pv_q, pv_d;
   logic [11:0]        px_q, px_d;
   logic               on_screen;

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      x_d     = x_q;
      col_d   = col_q;
      addr_d  = addr_q;
      pv_d    = (state_q == FETCH);
      // Sign-extend sprite_x to 12 bits so sprite_x+col never overflows.
      px_d    = {x_q[10], x_q} + {{(12-COL_W){1'b0}}, col_q};

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               id_d  = bus.sprite_id;
               x_d   = bus.sprite_x;
               col_d = '0;
               if (bus.sprite_row >= ROW_W'(SPRITE_H)) begin
                  state_d = DONE;
               end else begin
                  state_d = FETCH;
                  addr_d  = ADDR_W'(bus.sprite_row) * ADDR_W'(SPRITE_W);
               end
            end
         end
         FETCH: begin
            if (col_q == COL_W'(SPRITE_W - 1)) begin
               state_d = DRAIN;
            end else begin
               // A row is contiguous in storage, so the address just steps.
               col_d  = col_q + 1'b1;
               addr_d = addr_q + 1'b1;
            end
         end
         DRAIN:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         id_q    <= '0;
         x_q     <= '0;
         col_q   <= '0;
         addr_q  <= '0;
         pv_q    <= 1'b0;
         px_q    <= '0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         x_q     <= x_d;
         col_q   <= col_d;
         addr_q  <= addr_d;
         pv_q    <= pv_d;
         px_q    <= px_d;
      end
   end

   // Negative x has bit 11 set; no wrap-around, so anything outside
   // [0, LINE_W) is simply dropped.
   assign on_screen = !px_q[11] && (px_q < 12'(LINE_W));

   assign bus.busy          = (state_q == FETCH) || (state_q == DRAIN);
   assign bus.done          = (state_q == DONE);
   assign bus.r_en          = (state_q == FETCH);
   assign bus.r_addr        = addr_q;
   assign bus.sprite_select = id_q;
   assign bus.dbg_state     = state_q;

   // Pixel value 0 is transparent. Address/data are forced to 0 when no
   // write happens so stale r_data never shows up on the line buffer port.
   assign bus.lb_w_en   = pv_q && (bus.r_data != 4'h0) && on_screen;
   assign bus.lb_w_addr = bus.lb_w_en ? px_q[LB_W-1:0] : '0;
   assign bus.lb_w_data = bus.lb_w_en ? bus.r_data : 4'h0;
endmodule

// File: tb/tb_sprite_line_fetcher.sv
module tb_sprite_line_fetcher;
   localparam int NUM = 16;
   localparam int W   = 8;
   localparam int H   = 8;
   localparam int LW  = 64;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   sprite_line_fetcher_if #(.SPRITE_NUM(NUM), .SPRITE_W(W), .SPRITE_H(H), .LINE_W(LW)) bus();

   sprite_line_fetcher #(.SPRITE_NUM(NUM), .SPRITE_W(W), .SPRITE_H(H), .LINE_W(LW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- storage model (1-cycle read) ----------------
   logic [3:0] mem [0:NUM-1][0:W*H-1];

   always @(posedge clk) begin
      if (reset) bus.r_data <= 4'h0;
      else if (bus.r_en) bus.r_data <= mem[bus.sprite_select][bus.r_addr];
   end

   // ---------------- monitor ----------------
   logic [9:0] wr_q[$];
   int         wr_cyc[$];
   logic [5:0] rd_q[$];
   int         rd_cyc[$];
   int         done_cyc[$];
   int         busy_cyc[$];
   logic [9:0] exp_q[$];

   always @(negedge clk) begin
      if (bus.lb_w_en) begin
         wr_q.push_back({bus.lb_w_addr, bus.lb_w_data});
         wr_cyc.push_back(cyc);
      end
      if (bus.r_en) begin
         rd_q.push_back(bus.r_addr);
         rd_cyc.push_back(cyc);
      end
      if (bus.done) done_cyc.push_back(cyc);
      if (bus.busy) busy_cyc.push_back(cyc);
   end

   int checks = 0;
   int errors = 0;

   // ---------------- driver tasks ----------------
   task automatic clear_obs();
      wr_q.delete(); wr_cyc.delete(); rd_q.delete(); rd_cyc.delete();
      done_cyc.delete(); busy_cyc.delete(); exp_q.delete();
   endtask

   // Presents start for one cycle; t0 is the cycle in which start is high.
   task automatic do_start(input int id, input int x, input int row, output int t0);
      @(negedge clk);
      clear_obs();
      bus.sprite_id  = 4'(id);
      bus.sprite_x   = 11'(x);
      bus.sprite_row = 4'(row);
      bus.start      = 1'b1;
      t0 = cyc;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.r_en, bus.lb_w_en} !== 4'b0) begin
         errors++; $display("FAIL reset_ctrl got=%b want=0000", {bus.busy, bus.done, bus.r_en, bus.lb_w_en});
      end
      checks++;
      if (bus.r_addr !== 6'd0 || bus.sprite_select !== 4'd0 || bus.dbg_state !== 2'd0) begin
         errors++; $display("FAIL reset_regs addr=%0d sel=%0d st=%0d want 0 0 0", bus.r_addr, bus.sprite_select, bus.dbg_state);
      end
      #1 reset = 1'b0;
   endtask

   task automatic test_basic();
      int t0;
      do_start(1, 10, 2, t0);
      repeat (11) @(negedge clk);
      checks++;
      if (rd_q.size() != 8) begin errors++; $display("FAIL basic_nreads got=%0d want=8", rd_q.size()); end
      for (int i = 0; i < rd_q.size(); i++) begin
         checks++;
         if (rd_q[i] !== 6'(16 + i) || rd_cyc[i] != t0 + 1 + i) begin
            errors++; $display("FAIL basic_read[%0d] got addr=%0d cyc=%0d want addr=%0d cyc=%0d", i, rd_q[i], rd_cyc[i] - t0, 16 + i, 1 + i);
         end
      end
      for (int i = 0; i < 8; i++) exp_q.push_back({6'(10 + i), 4'(i + 1)});
      checks++;
      if (wr_q.size() != 8) begin errors++; $display("FAIL basic_nwrites got=%0d want=8", wr_q.size()); end
      for (int i = 0; i < wr_q.size() && i < 8; i++) begin
         checks++;
         if (wr_q[i] !== exp_q[i] || wr_cyc[i] != t0 + 2 + i) begin
            errors++; $display("FAIL basic_write[%0d] got %h@%0d want %h@%0d", i, wr_q[i], wr_cyc[i] - t0, exp_q[i], 2 + i);
         end
      end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != t0 + 10) begin
         errors++; $display("FAIL basic_done count=%0d want 1 at t0+10", done_cyc.size());
      end
      checks++;
      if (busy_cyc.size() != 9 || busy_cyc[0] != t0 + 1 || busy_cyc[8] != t0 + 9) begin
         errors++; $display("FAIL basic_busy count=%0d want 9 cycles t0+1..t0+9", busy_cyc.size());
      end
   endtask

   task automatic test_transparent();
      int t0;
      do_start(2, 0, 0, t0);
      repeat (11) @(negedge clk);
      for (int i = 0; i < 4; i++) exp_q.push_back({6'(2 * i + 1), 4'h5});
      checks++;
      if (wr_q.size() != 4) begin errors++; $display("FAIL transp_nwrites got=%0d want=4", wr_q.size()); end
      for (int i = 0; i < wr_q.size() && i < 4; i++) begin
         checks++;
         if (wr_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL transp_write[%0d] got=%h want=%h", i, wr_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_clip();
      int t0;
      // left edge: columns 3..7 land on 0..4
      do_start(4, -3, 7, t0);
      repeat (11) @(negedge clk);
      for (int i = 0; i < 5; i++) exp_q.push_back({6'(i), 4'hF});
      checks++;
      if (wr_q.size() != 5) begin errors++; $display("FAIL clip_left_n got=%0d want=5", wr_q.size()); end
      for (int i = 0; i < wr_q.size() && i < 5; i++) begin
         checks++;
         if (wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL clip_left[%0d] got=%h want=%h", i, wr_q[i], exp_q[i]); end
      end
      // right edge: columns 0..3 land on 60..63
      do_start(4, 60, 7, t0);
      repeat (11) @(negedge clk);
      for (int i = 0; i < 4; i++) exp_q.push_back({6'(60 + i), 4'hF});
      checks++;
      if (wr_q.size() != 4) begin errors++; $display("FAIL clip_right_n got=%0d want=4", wr_q.size()); end
      for (int i = 0; i < wr_q.size() && i < 4; i++) begin
         checks++;
         if (wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL clip_right[%0d] got=%h want=%h", i, wr_q[i], exp_q[i]); end
      end
      // fully off-screen
      do_start(4, 100, 7, t0);
      repeat (11) @(negedge clk);
      checks++;
      if (rd_q.size() != 8 || wr_q.size() != 0 || done_cyc.size() != 1) begin
         errors++; $display("FAIL clip_off reads=%0d writes=%0d dones=%0d want 8 0 1", rd_q.size(), wr_q.size(), done_cyc.size());
      end
   endtask

   task automatic test_bad_row();
      int t0;
      do_start(1, 10, 8, t0);
      repeat (4) @(negedge clk);
      checks++;
      if (rd_q.size() != 0 || wr_q.size() != 0) begin
         errors++; $display("FAIL badrow_access reads=%0d writes=%0d want 0 0", rd_q.size(), wr_q.size());
      end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != t0 + 1) begin
         errors++; $display("FAIL badrow_done count=%0d want 1 at t0+1", done_cyc.size());
      end
   endtask

   task automatic test_back_to_back();
      int t0;
      @(negedge clk);
      clear_obs();
      bus.sprite_id  = 4'd1;
      bus.sprite_x   = 11'd10;
      bus.sprite_row = 4'd2;
      bus.start      = 1'b1;
      t0 = cyc;
      repeat (20) @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (done_cyc.size() != 2) begin
         errors++; $display("FAIL b2b_ndone got=%0d want=2", done_cyc.size());
      end else begin
         checks++;
         if (done_cyc[0] != t0 + 10 || done_cyc[1] - done_cyc[0] != 11) begin
            errors++; $display("FAIL b2b_period first=t0+%0d period=%0d want t0+10 11", done_cyc[0] - t0, done_cyc[1] - done_cyc[0]);
         end
      end
      checks++;
      if (wr_q.size() != 16) begin errors++; $display("FAIL b2b_nwrites got=%0d want=16", wr_q.size()); end
   endtask

   task automatic test_mid_reset();
      int t0;
      int late;
      do_start(1, 10, 2, t0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.r_en, bus.lb_w_en} !== 4'b0 || bus.dbg_state !== 2'd0) begin
         errors++; $display("FAIL mreset_ctrl got=%b st=%0d want=0000 st=0", {bus.busy, bus.done, bus.r_en, bus.lb_w_en}, bus.dbg_state);
      end
      checks++;
      if (bus.r_addr !== 6'd0 || bus.sprite_select !== 4'd0 || bus.lb_w_addr !== 6'd0 || bus.lb_w_data !== 4'd0) begin
         errors++; $display("FAIL mreset_data addr=%0d sel=%0d lba=%0d lbd=%0d want all 0", bus.r_addr, bus.sprite_select, bus.lb_w_addr, bus.lb_w_data);
      end
      repeat (6) @(negedge clk);
      late = 0;
      foreach (wr_cyc[i]) if (wr_cyc[i] >= t0 + 5) late++;
      checks++;
      if (wr_q.size() != 3 || late != 0 || done_cyc.size() != 0) begin
         errors++; $display("FAIL mreset_writes total=%0d late=%0d dones=%0d want 3 0 0", wr_q.size(), late, done_cyc.size());
      end
      do_start(1, 10, 2, t0);
      repeat (11) @(negedge clk);
      for (int i = 0; i < 8; i++) exp_q.push_back({6'(10 + i), 4'(i + 1)});
      checks++;
      if (wr_q.size() != 8 || done_cyc.size() != 1 || done_cyc[0] != t0 + 10) begin
         errors++; $display("FAIL mreset_restart writes=%0d dones=%0d want 8 1", wr_q.size(), done_cyc.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL mreset_rewrite[%0d] got=%h want=%h", i, wr_q[i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_id_hold();
      int t0;
      do_start(1, 10, 2, t0);
      bus.sprite_id = 4'd3;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         checks++;
         if (bus.sprite_select !== 4'd1) begin
            errors++; $display("FAIL idhold_sel t0+%0d got=%0d want=1", i, bus.sprite_select);
         end
      end
      for (int i = 0; i < 8; i++) exp_q.push_back({6'(10 + i), 4'(i + 1)});
      checks++;
      if (wr_q.size() != 8) begin
         errors++; $display("FAIL idhold_nwrites got=%0d want=8", wr_q.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL idhold_write[%0d] got=%h want=%h", i, wr_q[i], exp_q[i]); end
         end
      end
      @(negedge clk);
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      bus.start      = 1'b0;
      bus.sprite_id  = '0;
      bus.sprite_x   = '0;
      bus.sprite_row = '0;
      for (int s = 0; s < NUM; s++)
         for (int a = 0; a < W * H; a++) mem[s][a] = 4'h0;
      for (int i = 0; i < W; i++) begin
         mem[1][16 + i] = 4'(i + 1);
         mem[3][16 + i] = 4'h9;
         mem[2][i]      = (i % 2 == 1) ? 4'h5 : 4'h0;
         mem[4][56 + i] = 4'hF;
      end

      test_reset();
      test_basic();
      test_transparent();
      test_clip();
      test_bad_row();
      test_back_to_back();
      test_mid_reset();
      test_id_hold();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
